// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered
//  Purpose  : Memory-mapped 8N1 UART transmitter with a small byte FIFO,
//             sticky overflow flag and per-frame completion pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow,
  output logic       tx_done
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0]  c_DEPTH     = c_CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]          c_LAST_BIT  = 3'd7;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_overflow;

  state_t              r_state;
  logic [c_BAUD_W-1:0] r_baud;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  state_t w_state_nxt;
  logic   w_baud_term;
  logic   w_pop;
  logic   w_push;
  logic   w_frame_done;
  logic   w_fifo_empty;
  logic   w_fifo_full;

  // FIFO occupancy flags come straight from the count register
  always_comb begin
    w_fifo_empty = (r_count == '0);
    w_fifo_full  = (r_count == c_DEPTH);
  end

  // Next-state logic: decides when to pop the FIFO and how the frame advances
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_frame_done = 1'b0;
    w_baud_term  = (r_baud == c_BAUD_LAST);

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end

      ST_START: begin
        if (w_baud_term) begin
          w_state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_baud_term && (r_bit_idx == c_LAST_BIT)) begin
          w_state_nxt = ST_STOP;
        end
      end

      ST_STOP: begin
        if (w_baud_term) begin
          w_frame_done = 1'b1;
          // Chain straight into the next frame so there is no idle gap
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A write is taken when there is room, or when a pop frees a slot this cycle
  always_comb begin
    w_push = wr_en && (!w_fifo_full || w_pop);
  end

  // Output decode: every output depends on registers only
  always_comb begin
    tx         = 1'b1;
    busy       = (r_state != ST_IDLE);
    fifo_full  = w_fifo_full;
    fifo_empty = w_fifo_empty;
    overflow   = r_overflow;
    tx_done    = w_frame_done;

    case (r_state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = r_shift[0];
      default:  tx = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Frame sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Baud counter: held at zero while idle, wraps at terminal count otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= '0;
    end else if ((r_state == ST_IDLE) || w_baud_term) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + c_BAUD_W'(1);
    end
  end

  // Data bit index: reset during the start bit, stepped at each data bit end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx <= '0;
    end else if (r_state == ST_START) begin
      r_bit_idx <= '0;
    end else if ((r_state == ST_DATA) && w_baud_term) begin
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  // Shift register: loads the FIFO head on pop, shifts right LSB-first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
    end else if ((r_state == ST_DATA) && w_baud_term) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // FIFO storage; contents need no reset since the count qualifies them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy count; pointers wrap at the power-of-2 depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a dropped write sets it and wins over a clear request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (wr_en && !w_push) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Memory-mapped UART transmitter that consumes byte stores routed to the UART region (address 0x8xxx_xxxx) by the load/store unit.
- Accepts one byte per write strobe into a small FIFO and serialises each byte onto `tx` as 8N1 (1 start, 8 data LSB-first, 1 stop).
- Exposes status flags that the load/store unit returns to the core on UART polling reads.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit period (>=2).
- FIFO_DEPTH, 4, byte entries in the transmit FIFO (power of 2, >=2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  byte write strobe (uart_sel & wr from LSU), one byte per high cycle.
- wr_data  input  8  byte to transmit; sampled when wr_en=1.
- clr_ovf  input  1  clears sticky overflow flag.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is being shifted (state != IDLE).
- fifo_full  output  1  count == FIFO_DEPTH.
- fifo_empty  output  1  count == 0.
- overflow  output  1  sticky: a write was dropped because the FIFO was full.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (rst_n=0, async):
  - tx=1, busy=0, fifo_full=0, fifo_empty=1, overflow=0, tx_done=0.
  - FIFO pointers and count cleared; FSM to IDLE; baud and bit counters cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high asynchronously.
- All outputs are registered or decoded from registers only; no combinational path from inputs to outputs.
- FIFO:
  - Circular buffer with read/write pointers plus a count of width $clog2(FIFO_DEPTH)+1.
  - A write is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. A simultaneous push and pop leaves count unchanged.
  - A write while full with no pop is dropped, FIFO contents are unchanged, and overflow is set at the next edge.
  - overflow clears on clr_ovf=1. If clr_ovf and a dropped write coincide, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After 8 bits go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. tx_done pulses in the final STOP cycle.
    - If the FIFO is non-empty in that final cycle: pop and go directly to START, so back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at terminal count, which advances the bit or state.
- Latency: wr_en sampled at edge E0 into an empty FIFO with the FSM idle → FSM pops at E1, tx low from E1.
  - The frame occupies 10*CLKS_PER_BIT cycles.
  - tx_done is high in the cycle ending at edge E1+10*CLKS_PER_BIT.
- A write in the same cycle the FSM pops from a single-entry FIFO is accepted; fifo_empty stays 0.
- busy=1 in START/DATA/STOP; busy=0 in IDLE even if the FIFO is non-empty for that single cycle.

Test Plan:
1. CLKS_PER_BIT=4. Reset, then wr_en=1, wr_data=0xA5 for one cycle.
   → tx, from the next edge, follows bits 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
   → tx_done pulses once; busy drops the cycle after; fifo_empty=1 throughout after the pop.
2. Write 0x00, 0xFF, 0x3C on consecutive cycles.
   → three frames back-to-back with no idle cycle between stop and next start.
   → bytes decode in order; 3 tx_done pulses spaced exactly 40 cycles apart.
3. FIFO_DEPTH=4, frame in progress. Write 5 bytes on consecutive cycles while the FSM is in DATA.
   → fifo_full=1 after the 4th write; the 5th is dropped; overflow=1.
   → only the in-flight byte plus the first 4 are transmitted.
   → clr_ovf pulse → overflow=0.
4. Full FIFO; drive wr_en=1 exactly in the STOP final cycle (pop cycle).
   → write accepted, fifo_full stays 1, overflow stays 0.
5. Assert rst_n=0 mid-DATA of a 0x55 frame with 2 bytes queued.
   → tx=1 immediately (async); busy=0, fifo_empty=1.
   → no further frames after rst_n deasserts.
6. Hold clr_ovf=1 while a full-FIFO write is dropped.
   → overflow=1 (set priority); the next cycle with clr_ovf=1 and no write → overflow=0.
